// File: rtl/mdu_hilo.sv
// Multiply/divide unit with architectural HI/LO for the EX stage.
// Fixed-latency MULT/MULTU/DIV/DIVU, single-cycle MTHI/MTLO, combinational MFHI/MFLO.
module mdu_hilo #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] num1,
    input  logic [31:0] num2,
    input  logic [3:0]  mdu_op,
    input  logic        req,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mdu_out
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [31:0]      r_hi;
    logic [31:0]      w_hi_nxt;
    logic [31:0]      r_lo;
    logic [31:0]      w_lo_nxt;
    logic [31:0]      r_pend_hi;
    logic [31:0]      w_pend_hi_nxt;
    logic [31:0]      r_pend_lo;
    logic [31:0]      w_pend_lo_nxt;
    logic             r_pend_we;
    logic             w_pend_we_nxt;

    logic             w_is_signed;
    logic [63:0]      w_mul_a;
    logic [63:0]      w_mul_b;
    logic [63:0]      w_prod;
    logic             w_neg_a;
    logic             w_neg_b;
    logic [31:0]      w_mag_a;
    logic [31:0]      w_mag_b;
    logic [31:0]      w_dvsr;
    logic [31:0]      w_q_mag;
    logic [31:0]      w_r_mag;
    logic [31:0]      w_quot;
    logic [31:0]      w_rem;
    logic             w_div_zero;

    assign w_is_signed = (mdu_op == OP_MULT) || (mdu_op == OP_DIV);

    // Sign-extending to 64 bits lets one unsigned multiplier serve both MULT and MULTU.
    assign w_mul_a = {{32{w_is_signed & num1[31]}}, num1};
    assign w_mul_b = {{32{w_is_signed & num2[31]}}, num2};
    assign w_prod  = w_mul_a * w_mul_b;

    // Magnitude divide then sign fix-up; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    assign w_neg_a    = w_is_signed & num1[31];
    assign w_neg_b    = w_is_signed & num2[31];
    assign w_mag_a    = w_neg_a ? (32'd0 - num1) : num1;
    assign w_mag_b    = w_neg_b ? (32'd0 - num2) : num2;
    assign w_div_zero = (num2 == 32'd0);
    assign w_dvsr     = w_div_zero ? 32'd1 : w_mag_b;
    assign w_q_mag    = w_mag_a / w_dvsr;
    assign w_r_mag    = w_mag_a % w_dvsr;
    assign w_quot     = (w_neg_a ^ w_neg_b) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_rem      = w_neg_a ? (32'd0 - w_r_mag) : w_r_mag;

    // Next-state, counter, pending-result and HI/LO update logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_busy_nxt    = r_busy;
        w_cnt_nxt     = r_cnt;
        w_hi_nxt      = r_hi;
        w_lo_nxt      = r_lo;
        w_pend_hi_nxt = r_pend_hi;
        w_pend_lo_nxt = r_pend_lo;
        w_pend_we_nxt = r_pend_we;
        case (r_state)
            S_IDLE: begin
                if (!req) begin
                    case (mdu_op)
                        OP_MULT, OP_MULTU: begin
                            w_state_nxt   = S_RUN;
                            w_busy_nxt    = 1'b1;
                            w_cnt_nxt     = CNT_MULT;
                            w_pend_hi_nxt = w_prod[63:32];
                            w_pend_lo_nxt = w_prod[31:0];
                            w_pend_we_nxt = 1'b1;
                        end
                        OP_DIV, OP_DIVU: begin
                            w_state_nxt   = S_RUN;
                            w_busy_nxt    = 1'b1;
                            w_cnt_nxt     = CNT_DIV;
                            w_pend_hi_nxt = w_rem;
                            w_pend_lo_nxt = w_quot;
                            w_pend_we_nxt = ~w_div_zero;
                        end
                        OP_MTHI: begin
                            w_hi_nxt = num1;
                        end
                        OP_MTLO: begin
                            w_lo_nxt = num1;
                        end
                        default: begin
                            w_state_nxt = S_IDLE;
                        end
                    endcase
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (r_cnt == CNT_ONE) begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_cnt_nxt   = CNT_ZERO;
                    if (r_pend_we) begin
                        w_hi_nxt = r_pend_hi;
                        w_lo_nxt = r_pend_lo;
                    end else begin
                        w_hi_nxt = r_hi;
                        w_lo_nxt = r_lo;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // State, counter, pending and architectural register storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_cnt     <= CNT_ZERO;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_we <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_busy    <= w_busy_nxt;
            r_cnt     <= w_cnt_nxt;
            r_hi      <= w_hi_nxt;
            r_lo      <= w_lo_nxt;
            r_pend_hi <= w_pend_hi_nxt;
            r_pend_lo <= w_pend_lo_nxt;
            r_pend_we <= w_pend_we_nxt;
        end
    end

    // MFHI/MFLO read path into the EX result mux.
    always_comb begin
        mdu_out = 32'd0;
        case (mdu_op)
            OP_MFHI: mdu_out = r_hi;
            OP_MFLO: mdu_out = r_lo;
            default: mdu_out = 32'd0;
        endcase
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
